// File: rtl/colour_pkg.sv
// Shared constants and helpers for the colour channel mapper slice.
package colour_pkg;

   localparam int NCH_DEFAULT = 3;
   localparam int CW_DEFAULT  = 4;

   // Select code that forces a channel to zero: the first code after the channel indices.
   function automatic int sel_zero(input int n);
      return n;
   endfunction

   // Lowest select code that passes a channel's own input through untouched.
   function automatic int sel_pass(input int n);
      return n + 1;
   endfunction

   // (a + b) mod n for a, b already below n, so a single conditional subtract suffices.
   function automatic int wrap_add(input int a, input int b, input int n);
      int sum;
      sum = a + b;
      if (sum >= n) begin
         sum = sum - n;
      end
      return sum;
   endfunction

endpackage

// File: rtl/colour_frame_ctrl.sv
// Frame-level control: vsync edge detection, shadow config register and auto-rotate counters.
module colour_frame_ctrl
   import colour_pkg::*;
#(
   parameter int NCH         = NCH_DEFAULT,
   parameter int SELW        = $clog2(NCH + 2),
   parameter bit VS_POL      = 1'b0,
   parameter int AUTO_FRAMES = 60
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vs_s1,
   input  logic [NCH*SELW-1:0]  cfg_sel,
   input  logic [NCH-1:0]       cfg_inv,
   input  logic                 auto_en,
   output logic [NCH*SELW-1:0]  act_sel,
   output logic [NCH-1:0]       act_inv,
   output logic [SELW-1:0]      rot,
   output logic                 cfg_applied
);

   localparam int               FCW       = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [FCW-1:0]   FCNT_LAST = FCW'(AUTO_FRAMES - 1);
   localparam logic [SELW-1:0]  ROT_LAST  = SELW'(NCH - 1);

   logic           vs_prev;
   logic           fs;
   logic [FCW-1:0] fcnt;

   assign fs = (vs_s1 == VS_POL) && (vs_prev != VS_POL);

   // Remember last cycle's registered vsync so the move into the active level can be seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_prev <= ~VS_POL;
      end else begin
         vs_prev <= vs_s1;
      end
   end

   // Shadow config: switches are only taken at frame start so a frame never tears.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            act_sel[i*SELW +: SELW] <= SELW'(i);
         end
         act_inv     <= '0;
         cfg_applied <= 1'b0;
      end else begin
         cfg_applied <= fs;
         if (fs) begin
            act_sel <= cfg_sel;
            act_inv <= cfg_inv;
         end
      end
   end

   // Frame counter and rotation offset; leaving auto mode clears both at the next frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
         rot  <= '0;
      end else if (fs) begin
         if (auto_en) begin
            if (fcnt == FCNT_LAST) begin
               fcnt <= '0;
               rot  <= (rot == ROT_LAST) ? '0 : rot + SELW'(1);
            end else begin
               fcnt <= fcnt + FCW'(1);
            end
         end else begin
            fcnt <= '0;
            rot  <= '0;
         end
      end
   end

endmodule

// File: rtl/colour_channel_mapper.sv
// Two-stage per-channel colour remapper between the filter stage and the VGA driver.
module colour_channel_mapper
   import colour_pkg::*;
#(
   parameter int NCH         = NCH_DEFAULT,
   parameter int CW          = CW_DEFAULT,
   parameter int SELW        = $clog2(NCH + 2),
   parameter bit VS_POL      = 1'b0,
   parameter int AUTO_FRAMES = 60
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*SELW-1:0]  cfg_sel,
   input  logic [NCH-1:0]       cfg_inv,
   input  logic                 auto_en,
   input  logic [NCH*CW-1:0]    pix_in,
   input  logic                 de_in,
   input  logic                 hs_in,
   input  logic                 vs_in,
   output logic [NCH*CW-1:0]    pix_out,
   output logic                 de_out,
   output logic                 hs_out,
   output logic                 vs_out,
   output logic                 cfg_applied,
   output logic [SELW-1:0]      rot_out
);

   localparam logic [SELW-1:0] SEL_ZERO_CODE = SELW'(sel_zero(NCH));
   localparam logic [SELW-1:0] SEL_PASS_CODE = SELW'(sel_pass(NCH));

   logic [NCH*CW-1:0]   pix_s1;
   logic                de_s1;
   logic                hs_s1;
   logic                vs_s1;
   logic [NCH*CW-1:0]   mapped;
   logic [NCH*SELW-1:0] act_sel;
   logic [NCH-1:0]      act_inv;
   logic [SELW-1:0]     rot;

   colour_frame_ctrl #(
      .NCH         (NCH),
      .SELW        (SELW),
      .VS_POL      (VS_POL),
      .AUTO_FRAMES (AUTO_FRAMES)
   ) u_frame_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .vs_s1       (vs_s1),
      .cfg_sel     (cfg_sel),
      .cfg_inv     (cfg_inv),
      .auto_en     (auto_en),
      .act_sel     (act_sel),
      .act_inv     (act_inv),
      .rot         (rot),
      .cfg_applied (cfg_applied)
   );

   assign rot_out = rot;

   // Stage 1: capture the incoming pixel and syncs; syncs reset to their inactive level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_s1 <= '0;
         de_s1  <= 1'b0;
         hs_s1  <= ~VS_POL;
         vs_s1  <= ~VS_POL;
      end else begin
         pix_s1 <= pix_in;
         de_s1  <= de_in;
         hs_s1  <= hs_in;
         vs_s1  <= vs_in;
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic [SELW-1:0] sel_code;
      logic [CW-1:0]   chan_val;
      int              src;

      assign sel_code = act_sel[i*SELW +: SELW];

      // Pick rotated source, zero or own channel, then apply the optional invert.
      always_comb begin
         chan_val = '0;
         src      = wrap_add(int'(sel_code), int'(rot), NCH);
         if (sel_code < SEL_ZERO_CODE) begin
            for (int j = 0; j < NCH; j++) begin
               if (src == j) begin
                  chan_val = pix_s1[j*CW +: CW];
               end
            end
         end else if (sel_code >= SEL_PASS_CODE) begin
            chan_val = pix_s1[i*CW +: CW];
         end
         if (act_inv[i]) begin
            chan_val = ~chan_val;
         end
      end

      assign mapped[i*CW +: CW] = chan_val;
   end

   // Stage 2: register the remapped pixel, blanking it whenever video is inactive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_out <= '0;
         de_out  <= 1'b0;
         hs_out  <= ~VS_POL;
         vs_out  <= ~VS_POL;
      end else begin
         pix_out <= de_s1 ? mapped : '0;
         de_out  <= de_s1;
         hs_out  <= hs_s1;
         vs_out  <= vs_s1;
      end
   end

endmodule

// File: tb/tb_colour_channel_mapper.sv
// Self-checking bench for colour_channel_mapper using an expected-result queue.
module tb_colour_channel_mapper;

   localparam int NCH  = 3;
   localparam int CW   = 4;
   localparam int SELW = 3;

   typedef struct {
      int          due;
      logic [11:0] pix;
      logic        de;
      logic        hs;
      logic        vs;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH*SELW-1:0] cfg_sel;
   logic [NCH-1:0]    cfg_inv;
   logic              auto_en;
   logic [NCH*CW-1:0] pix_in;
   logic              de_in;
   logic              hs_in;
   logic              vs_in;
   logic [NCH*CW-1:0] pix_out;
   logic              de_out;
   logic              hs_out;
   logic              vs_out;
   logic              cfg_applied;
   logic [SELW-1:0]   rot_out;

   int   testsRun    = 0;
   int   testsFailed = 0;
   int   cyc         = 0;
   exp_t expQ[$];
   exp_t monEntry;

   int          mSel[NCH];
   logic [2:0]  mInv;
   int          mRot;

   int rotTableA[5] = '{0, 1, 1, 2, 2};
   int rotTableB[8] = '{0, 1, 1, 2, 2, 0, 0, 1};

   colour_channel_mapper #(
      .NCH         (NCH),
      .CW          (CW),
      .VS_POL      (1'b0),
      .AUTO_FRAMES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_sel     (cfg_sel),
      .cfg_inv     (cfg_inv),
      .auto_en     (auto_en),
      .pix_in      (pix_in),
      .de_in       (de_in),
      .hs_in       (hs_in),
      .vs_in       (vs_in),
      .pix_out     (pix_out),
      .de_out      (de_out),
      .hs_out      (hs_out),
      .vs_out      (vs_out),
      .cfg_applied (cfg_applied),
      .rot_out     (rot_out)
   );

   // Free-running pixel clock
   always #5 clk = ~clk;

   // Cycle counter used to schedule when each queued expectation is due
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Count one comparison and report it if the observed value is not the expected one
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference mapping written straight from the select-code rules
   function automatic logic [11:0] modelPix(input logic [11:0] p, input logic de);
      logic [11:0] r;
      logic [3:0]  v;
      int          s;
      r = '0;
      if (de) begin
         for (int i = 0; i < NCH; i++) begin
            s = mSel[i];
            if (s < NCH)       v = p[((s + mRot) % NCH)*CW +: CW];
            else if (s == NCH) v = 4'h0;
            else               v = p[i*CW +: CW];
            if (mInv[i]) v = ~v;
            r[i*CW +: CW] = v;
         end
      end
      return r;
   endfunction

   // Drive one pixel for a cycle; optionally queue what must appear two cycles later
   task automatic applyStimulus(input logic [11:0] pix, input logic de, input logic hs,
                                input logic [11:0] expPix, input bit check);
      exp_t e;
      pix_in = pix;
      de_in  = de;
      hs_in  = hs;
      vs_in  = 1'b1;
      if (check) begin
         e.due = cyc + 2;
         e.pix = expPix;
         e.de  = de;
         e.hs  = hs;
         e.vs  = 1'b1;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Drive a pixel whose expectation comes from the reference mapping
   task automatic drivePixel(input logic [11:0] pix, input logic de, input logic hs);
      applyStimulus(pix, de, hs, modelPix(pix, de), 1'b1);
   endtask

   // Select codes given in R, G, B order (R is the top channel)
   task automatic setSel(input int r, input int g, input int b);
      cfg_sel = {3'(r), 3'(g), 3'(b)};
   endtask

   // Two-cycle vsync pulse; checks the cfg_applied pulse and the new rotation
   task automatic frameStart(input int expRot);
      vs_in = 1'b0;
      de_in = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("cfgAppliedBefore", 32'(cfg_applied), 32'd0);
      @(posedge clk);
      #1;
      vs_in = 1'b1;
      @(negedge clk);
      checkOutput("cfgAppliedPulse", 32'(cfg_applied), 32'd1);
      checkOutput("rotAfterFs", 32'(rot_out), 32'(expRot));
      for (int i = 0; i < NCH; i++) mSel[i] = int'(cfg_sel[i*SELW +: SELW]);
      mInv = cfg_inv;
      mRot = expRot;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("cfgAppliedAfter", 32'(cfg_applied), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Pop every expectation that has come due and compare it against the outputs
   always @(negedge clk) begin
      while (expQ.size() > 0 && expQ[0].due <= cyc) begin
         monEntry = expQ.pop_front();
         if (monEntry.due != cyc) checkOutput("queueLate", 32'(cyc), 32'(monEntry.due));
         checkOutput("pixOut", 32'(pix_out), 32'(monEntry.pix));
         checkOutput("deOut",  32'(de_out),  32'(monEntry.de));
         checkOutput("hsOut",  32'(hs_out),  32'(monEntry.hs));
         checkOutput("vsOut",  32'(vs_out),  32'(monEntry.vs));
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence
   initial begin
      rst_n   = 1'b0;
      cfg_inv = 3'b000;
      auto_en = 1'b0;
      pix_in  = '0;
      de_in   = 1'b0;
      hs_in   = 1'b1;
      vs_in   = 1'b1;
      setSel(2, 1, 0);
      mSel = '{0, 1, 2};
      mInv = 3'b000;
      mRot = 0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstPix", 32'(pix_out), 32'd0);
      checkOutput("rstDe", 32'(de_out), 32'd0);
      checkOutput("rstHs", 32'(hs_out), 32'd1);
      checkOutput("rstVs", 32'(vs_out), 32'd1);
      checkOutput("rstCfgApplied", 32'(cfg_applied), 32'd0);
      checkOutput("rstRot", 32'(rot_out), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Identity mapping and sync alignment
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h3A5, 1'b1);
      applyStimulus(12'h3A5, 1'b1, 1'b0, 12'h3A5, 1'b1);
      for (int k = 0; k < 4; k++) drivePixel(12'($urandom), 1'b1, 1'b1);
      drivePixel(12'hFFF, 1'b0, 1'b1);

      // Config change mid-frame is ignored until frame start
      setSel(0, 2, 2);
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h3A5, 1'b1);
      drivePixel(12'h7C1, 1'b1, 1'b1);
      frameStart(0);
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h533, 1'b1);
      for (int k = 0; k < 3; k++) drivePixel(12'($urandom), 1'b1, 1'b1);

      // Zero and pass codes with invert
      setSel(3, 4, 0);
      cfg_inv = 3'b110;
      frameStart(0);
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'hF55, 1'b1);
      drivePixel(12'($urandom), 1'b1, 1'b1);
      drivePixel(12'h123, 1'b0, 1'b1);

      // Auto-rotate across frames with identity selects
      setSel(2, 1, 0);
      cfg_inv = 3'b000;
      auto_en = 1'b1;
      for (int f = 0; f < 5; f++) begin
         frameStart(rotTableA[f]);
         drivePixel(12'h3A5, 1'b1, 1'b1);
         drivePixel(12'($urandom), 1'b1, 1'b1);
         if (rotTableA[f] == 1) applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h53A, 1'b1);
      end

      // Leaving auto mode holds rotation until the next frame start
      auto_en = 1'b0;
      drivePixel(12'h3A5, 1'b1, 1'b1);
      drivePixel(12'h9E4, 1'b1, 1'b1);
      @(negedge clk);
      checkOutput("rotHeld", 32'(rot_out), 32'd2);
      @(posedge clk);
      #1;
      frameStart(0);
      drivePixel(12'h3A5, 1'b1, 1'b1);

      // Re-enable: frame counter restarted, rotation wraps 2 -> 0
      auto_en = 1'b1;
      for (int f = 0; f < 8; f++) begin
         frameStart(rotTableB[f]);
         drivePixel(12'h3A5, 1'b1, 1'b1);
         drivePixel(12'($urandom), 1'b1, 1'b1);
      end

      // Blanking and reset mid-line
      drivePixel(12'hABC, 1'b0, 1'b1);
      drivePixel(12'h3A5, 1'b1, 1'b1);
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h000, 1'b0);
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h000, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstPix", 32'(pix_out), 32'd0);
      checkOutput("midRstDe", 32'(de_out), 32'd0);
      checkOutput("midRstRot", 32'(rot_out), 32'd0);
      setSel(3, 3, 3);
      cfg_inv = 3'b101;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      mSel = '{0, 1, 2};
      mInv = 3'b000;
      mRot = 0;
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'h3A5, 1'b1);
      drivePixel(12'h6D2, 1'b1, 1'b1);
      frameStart(0);
      applyStimulus(12'h3A5, 1'b1, 1'b1, 12'hF0F, 1'b1);
      drivePixel(12'h6D2, 1'b1, 1'b1);

      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("queueDrained", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
